fe_prefetch: RTL and testbench
==============================

FE_PREFETCH -- requirements
Module: fe_prefetch

Interface
REQ-001 ADDR_W, 32, address/PC width in bits.
REQ-002 INSTR_W, 32, instruction width in bits; multiple of 8; PC increment = INSTR_W/8.
REQ-003 DEPTH, 4, prefetch queue entries; power of 2, >= 2.
REQ-004 RESET_PC, 0, first fetch address after reset.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 clr_n  in  1  reset, asynchronous assert, active-low.
REQ-007 i_branch  in  1  redirect request from execute stage.
REQ-008 i_branch_addr  in  ADDR_W  redirect target.
REQ-009 o_mem_req  out  1  instruction memory request valid.
REQ-010 o_mem_addr  out  ADDR_W  request address.
REQ-011 i_mem_gnt  in  1  request accepted this cycle when o_mem_req=1.
REQ-012 i_mem_rvalid  in  1  in-order response valid, >= 1 cycle after grant.
REQ-013 i_mem_rdata  in  INSTR_W  response instruction.
REQ-014 o_valid  out  1  queue head valid to decode.
REQ-015 o_pc  out  ADDR_W  PC of queue head.
REQ-016 o_instr  out  INSTR_W  instruction of queue head.
REQ-017 i_ready  in  1  decode accepts head; pop when o_valid & i_ready.

Function
REQ-018 State: fetch PC f_pc, queue of DEPTH {pc, instr} entries with wrapping rd/wr pointers and count, outstanding counter out_cnt, discard counter disc_cnt; counters clog2(DEPTH)+1 bits.
REQ-019 o_mem_req SHALL be 1 iff count + out_cnt < DEPTH (credit) and no redirect suppresses it (REQ-026/027).
REQ-020 On o_mem_req & i_mem_gnt: out_cnt += 1, f_pc += INSTR_W/8 modulo 2^ADDR_W (wrap, no error).
REQ-021 On i_mem_rvalid: out_cnt -= 1; if disc_cnt > 0, response dropped and disc_cnt -= 1; else {pc, rdata} written at wr pointer; pc per entry tracked in request order.
REQ-022 Grant and response in same cycle: out_cnt unchanged.
REQ-023 o_valid = (count != 0) & ~i_branch; o_pc/o_instr driven from rd pointer entry.
REQ-024 Simultaneous push and pop with queue full or empty: both take effect, count unchanged; credit rule guarantees no overflow; push into full queue is a design error (bench assertion).
REQ-025 On i_branch=1: queue flushed (count=0, pointers reset), pop ignored, response arriving this cycle dropped, disc_cnt <= out_cnt - i_mem_rvalid (all prior in-flight responses discarded).
REQ-026 Redirect without bypass: o_mem_req=0 in branch cycle; f_pc <= i_branch_addr; fetch resumes next cycle.
REQ-027 Redirect with bypass: see REQ-032.
REQ-028 Back-to-back branches: each flushes; latest target wins.
REQ-029 Latency: instruction visible on o_valid the cycle after i_mem_rvalid.

Reset
REQ-030 While clr_n=0: f_pc=RESET_PC, queue empty, out_cnt=0, disc_cnt=0, o_mem_req=0, o_valid=0, o_pc=0, o_instr=0, o_mem_addr=RESET_PC; reset mid-transaction SHALL abandon in-flight requests (memory is reset by same signal).
REQ-031 First request SHALL be asserted in the first cycle after clr_n rises.

Configuration
REQ-032 Macro FE_BRANCH_BYPASS_EN defined: in branch cycle o_mem_addr = i_branch_addr and o_mem_req = (out_cnt < DEPTH); if granted, f_pc <= i_branch_addr + INSTR_W/8, out_cnt += 1, and that request is NOT counted in disc_cnt; otherwise f_pc <= i_branch_addr.
REQ-033 Macro undefined: o_mem_addr = f_pc always; REQ-026 applies (one-cycle redirect bubble).

Verification
REQ-034 Reset release, gnt=1, 1-cycle rvalid, ready=1: o_pc sequence 0x0,0x4,0x8,... one per cycle.
REQ-035 ready=0, gnt=1, DEPTH=4: exactly 4 requests issued, o_mem_req=0 after; ready=1 for one cycle -> one new request.
REQ-036 3 requests outstanding (latency 5), branch to 0x100: 3 responses dropped, first o_pc after branch = 0x100.
REQ-037 Branch asserted with o_valid=1, ready=1: head not consumed, o_valid=0 that cycle, queue empty next cycle.
REQ-038 f_pc = 2^ADDR_W-4: next request address 0x0.
REQ-039 Bypass on: branch to 0x200 with gnt=1 -> o_mem_addr=0x200 in branch cycle, next address 0x204; bypass off -> 0x200 issued one cycle later.

Source files
------------

// File: rtl/fe_prefetch_if.sv
// Front-end prefetch bus bundle.
// Groups the redirect, instruction-memory and decode-side signals of fe_prefetch.
//   master : the prefetcher (drives o_*, samples i_*)
//   slave  : the environment (execute stage, instruction memory, decode)
// Signals:
//   i_branch/i_branch_addr        redirect request and target
//   o_mem_req/o_mem_addr          instruction memory request
//   i_mem_gnt                     request accepted this cycle
//   i_mem_rvalid/i_mem_rdata      in-order response
//   o_valid/o_pc/o_instr          queue head towards decode
//   i_ready                       decode accepts head
interface fe_prefetch_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               i_branch;
  logic [ADDR_W-1:0]  i_branch_addr;
  logic               o_mem_req;
  logic [ADDR_W-1:0]  o_mem_addr;
  logic               i_mem_gnt;
  logic               i_mem_rvalid;
  logic [INSTR_W-1:0] i_mem_rdata;
  logic               o_valid;
  logic [ADDR_W-1:0]  o_pc;
  logic [INSTR_W-1:0] o_instr;
  logic               i_ready;

  modport master (
    input  i_branch, i_branch_addr, i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_ready,
    output o_mem_req, o_mem_addr, o_valid, o_pc, o_instr
  );

  modport slave (
    output i_branch, i_branch_addr, i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_ready,
    input  o_mem_req, o_mem_addr, o_valid, o_pc, o_instr
  );
endinterface

// File: rtl/fe_prefetch.sv
// Instruction prefetch unit.
// Issues sequential fetch requests while credit (queued + in-flight < DEPTH) allows,
// buffers in-order responses in a DEPTH-entry {pc, instr} queue and presents the head
// to decode. A branch flushes the queue and marks every earlier in-flight response
// for discard.
// Ports:
//   clk    rising-edge clock
//   clr_n  asynchronous active-low reset
//   bus    fe_prefetch_if.master (redirect, memory and decode signals)
// Configuration:
//   FE_BRANCH_BYPASS_EN  when defined, the branch target is requested in the branch
//                        cycle itself instead of one cycle later.
module fe_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          clr_n,
  fe_prefetch_if.master bus
);

  localparam int unsigned       PtrW   = $clog2(DEPTH);
  localparam int unsigned       CntW   = PtrW + 1;
  localparam logic [ADDR_W-1:0] PcInc  = ADDR_W'(INSTR_W / 8);
  localparam logic [CntW:0]     DepthS = (CntW + 1)'(DEPTH);

  logic [ADDR_W-1:0]  f_pc_q, f_pc_d;
  // PC of the next response that will be kept; responses arrive in request order.
  logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [CntW-1:0]    out_cnt_q, out_cnt_d;
  logic [CntW-1:0]    disc_cnt_q, disc_cnt_d;
  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [ADDR_W-1:0]  pc_d    [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [INSTR_W-1:0] instr_d [DEPTH];

  logic credit;
  logic mem_req;
  logic mem_fire;
  logic valid;
  logic pop;
  logic push;

  always_comb begin
    credit = ({1'b0, count_q} + {1'b0, out_cnt_q}) < DepthS;
`ifdef FE_BRANCH_BYPASS_EN
    // The queue is flushed in the branch cycle, so only in-flight requests use credit.
    mem_req         = clr_n & (bus.i_branch ? (out_cnt_q < CntW'(DEPTH)) : credit);
    bus.o_mem_addr  = (clr_n & bus.i_branch) ? bus.i_branch_addr : f_pc_q;
`else
    mem_req         = clr_n & credit & ~bus.i_branch;
    bus.o_mem_addr  = f_pc_q;
`endif
    bus.o_mem_req = mem_req;
    mem_fire      = mem_req & bus.i_mem_gnt;
    valid         = (count_q != '0) & ~bus.i_branch;
    bus.o_valid   = valid;
    bus.o_pc      = pc_q[rd_ptr_q];
    bus.o_instr   = instr_q[rd_ptr_q];
    pop           = valid & bus.i_ready;
    push          = bus.i_mem_rvalid & ~bus.i_branch & (disc_cnt_q == '0);
  end

  always_comb begin
    f_pc_d     = f_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    out_cnt_d  = out_cnt_q;
    disc_cnt_d = disc_cnt_q;
    pc_d       = pc_q;
    instr_d    = instr_q;

    if (bus.i_branch) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Everything already in flight is stale; a response landing now is dropped here.
      disc_cnt_d = out_cnt_q - CntW'(bus.i_mem_rvalid);
      // mem_fire can only be set here with the bypass enabled; that request is kept.
      out_cnt_d  = out_cnt_q - CntW'(bus.i_mem_rvalid) + CntW'(mem_fire);
      f_pc_d     = mem_fire ? bus.i_branch_addr + PcInc : bus.i_branch_addr;
      resp_pc_d  = bus.i_branch_addr;
    end else begin
      out_cnt_d = out_cnt_q + CntW'(mem_fire) - CntW'(bus.i_mem_rvalid);
      if (mem_fire) begin
        f_pc_d = f_pc_q + PcInc;
      end
      if (bus.i_mem_rvalid && (disc_cnt_q != '0)) begin
        disc_cnt_d = disc_cnt_q - 1'b1;
      end
      if (push) begin
        pc_d[wr_ptr_q]    = resp_pc_q;
        instr_d[wr_ptr_q] = bus.i_mem_rdata;
        wr_ptr_d          = wr_ptr_q + 1'b1;
        resp_pc_d         = resp_pc_q + PcInc;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      f_pc_q     <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      f_pc_q     <= f_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

endmodule

// File: tb/tb_fe_prefetch.sv
// Directed bench for fe_prefetch. A small in-order memory model answers each granted
// request after `lat` cycles with data = ~address. Inputs change 1 time unit after the
// rising edge; outputs are checked one unit later, well before the next edge.
module tb_fe_prefetch;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DEPTH   = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } req_t;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat = 1;
  int   nreq;
  logic found;
  req_t pend[$];

  always #5 clk = ~clk;

  fe_prefetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  fe_prefetch #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  function automatic logic [31:0] inv(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: record a grant, then present any response that is due.
  task automatic tick();
    req_t r;
    if (bus.o_mem_req && bus.i_mem_gnt) begin
      r.addr = bus.o_mem_addr;
      r.due  = cyc + lat;
      pend.push_back(r);
    end
    @(posedge clk);
    #1;
    if (!clr_n) pend.delete();
    cyc++;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = inv(pend[0].addr);
      void'(pend.pop_front());
    end
    chk("inflight_bound", 64'(pend.size() <= DEPTH), 64'd1);
    #1;
  endtask

  task automatic do_reset();
    clr_n             = 1'b0;
    bus.i_branch      = 1'b0;
    bus.i_branch_addr = '0;
    bus.i_mem_gnt     = 1'b0;
    bus.i_mem_rvalid  = 1'b0;
    bus.i_mem_rdata   = '0;
    bus.i_ready       = 1'b0;
    pend.delete();
    #1;
    chk("rst_req", bus.o_mem_req, 64'd0);
    chk("rst_valid", bus.o_valid, 64'd0);
    chk("rst_pc", bus.o_pc, 64'd0);
    chk("rst_instr", bus.o_instr, 64'd0);
    chk("rst_addr", bus.o_mem_addr, 64'd0);
    tick();
    tick();
    clr_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming: one instruction per cycle from reset.
    do_reset();
    lat = 1;
    bus.i_mem_gnt = 1'b1;
    bus.i_ready   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("seq_req", bus.o_mem_req, 64'd1);
      chk("seq_addr", bus.o_mem_addr, 64'(32'(4 * c)));
      if (c >= 2) begin
        chk("seq_valid", bus.o_valid, 64'd1);
        chk("seq_pc", bus.o_pc, 64'(32'(4 * (c - 2))));
        chk("seq_instr", bus.o_instr, 64'(inv(32'(4 * (c - 2)))));
      end else begin
        chk("seq_empty", bus.o_valid, 64'd0);
      end
      tick();
    end

    // Reset mid-stream, then fill the queue with decode stalled.
    do_reset();
    lat = 1;
    bus.i_mem_gnt = 1'b1;
    bus.i_ready   = 1'b0;
    #1;
    chk("first_req", bus.o_mem_req, 64'd1);
    chk("first_addr", bus.o_mem_addr, 64'd0);
    nreq = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.o_mem_req && bus.i_mem_gnt) nreq++;
      tick();
    end
    chk("fill_nreq", 64'(nreq), 64'd4);
    #1;
    chk("fill_stall", bus.o_mem_req, 64'd0);
    chk("fill_head", bus.o_pc, 64'd0);
    bus.i_ready = 1'b1;
    #1;
    chk("pop_valid", bus.o_valid, 64'd1);
    chk("pop_noreq", bus.o_mem_req, 64'd0);
    tick();
    bus.i_ready = 1'b0;
    #1;
    chk("refill_req", bus.o_mem_req, 64'd1);
    chk("refill_addr", bus.o_mem_addr, 64'h10);
    chk("refill_head", bus.o_pc, 64'h4);
    tick();
    #1;
    chk("refill_stall", bus.o_mem_req, 64'd0);

    // Branch with three requests in flight (latency 5).
    do_reset();
    lat = 5;
    bus.i_mem_gnt = 1'b1;
    bus.i_ready   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tick();
    end
    bus.i_mem_gnt     = 1'b0;
    bus.i_branch      = 1'b1;
    bus.i_branch_addr = 32'h100;
    #1;
    chk("br_valid0", bus.o_valid, 64'd0);
`ifdef FE_BRANCH_BYPASS_EN
    chk("br_bypass_req", bus.o_mem_req, 64'd1);
    chk("br_bypass_addr", bus.o_mem_addr, 64'h100);
`else
    chk("br_bubble_req", bus.o_mem_req, 64'd0);
`endif
    tick();
    bus.i_branch  = 1'b0;
    bus.i_mem_gnt = 1'b1;
    #1;
    chk("br_req", bus.o_mem_req, 64'd1);
    chk("br_addr", bus.o_mem_addr, 64'h100);
    tick();
    bus.i_mem_gnt = 1'b0;
    for (int c = 5; c < 10; c++) begin
      #1;
      chk("br_drop", bus.o_valid, 64'd0);
      tick();
    end
    #1;
    chk("br_tgt_valid", bus.o_valid, 64'd1);
    chk("br_tgt_pc", bus.o_pc, 64'h100);
    chk("br_tgt_instr", bus.o_instr, 64'(inv(32'h100)));

    // Branch while the head is valid and decode is ready.
    bus.i_branch      = 1'b1;
    bus.i_branch_addr = 32'h300;
    #1;
    chk("brpop_valid", bus.o_valid, 64'd0);
    tick();
    bus.i_branch = 1'b0;
    #1;
    chk("brpop_flushed", bus.o_valid, 64'd0);
    chk("brpop_req", bus.o_mem_req, 64'd1);
    chk("brpop_addr", bus.o_mem_addr, 64'h300);

    // Fetch PC wraps at the top of the address space.
    do_reset();
    lat = 1;
    bus.i_ready       = 1'b1;
    bus.i_mem_gnt     = 1'b0;
    bus.i_branch      = 1'b1;
    bus.i_branch_addr = 32'hFFFF_FFFC;
    #1;
    tick();
    bus.i_branch  = 1'b0;
    bus.i_mem_gnt = 1'b1;
    #1;
    chk("wrap_top", bus.o_mem_addr, 64'hFFFF_FFFC);
    tick();
    #1;
    chk("wrap_req", bus.o_mem_req, 64'd1);
    chk("wrap_addr", bus.o_mem_addr, 64'd0);
    tick();
    #1;
    chk("wrap_pc_top", bus.o_pc, 64'hFFFF_FFFC);
    tick();
    #1;
    chk("wrap_pc_zero", bus.o_pc, 64'd0);

    // Redirect timing with grant held high.
    do_reset();
    lat = 1;
    bus.i_ready       = 1'b1;
    bus.i_mem_gnt     = 1'b1;
    bus.i_branch      = 1'b1;
    bus.i_branch_addr = 32'h200;
    #1;
`ifdef FE_BRANCH_BYPASS_EN
    chk("redir_req", bus.o_mem_req, 64'd1);
    chk("redir_addr", bus.o_mem_addr, 64'h200);
    tick();
    bus.i_branch = 1'b0;
    #1;
    chk("redir_next", bus.o_mem_addr, 64'h204);
    tick();
`else
    chk("redir_req", bus.o_mem_req, 64'd0);
    chk("redir_addr", bus.o_mem_addr, 64'd0);
    tick();
    bus.i_branch = 1'b0;
    #1;
    chk("redir_req1", bus.o_mem_req, 64'd1);
    chk("redir_addr1", bus.o_mem_addr, 64'h200);
    tick();
    #1;
    chk("redir_next", bus.o_mem_addr, 64'h204);
    tick();
`endif
    #1;
    chk("redir_pc", bus.o_pc, 64'h200);
    chk("redir_valid", bus.o_valid, 64'd1);

    // Back-to-back branches: the later target wins.
    do_reset();
    lat = 1;
    bus.i_ready       = 1'b1;
    bus.i_mem_gnt     = 1'b1;
    bus.i_branch      = 1'b1;
    bus.i_branch_addr = 32'h400;
    #1;
    tick();
    bus.i_branch_addr = 32'h500;
    #1;
    tick();
    bus.i_branch = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      #1;
      if (bus.o_valid) found = 1'b1;
      else tick();
    end
    chk("b2b_found", found, 64'd1);
    chk("b2b_pc", bus.o_pc, 64'h500);
    chk("b2b_instr", bus.o_instr, 64'(inv(32'h500)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
